// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB definitions: master encodings, HTRANS/HBURST/HRESP codes and a
// helper that maps a burst type to the number of beats following its NONSEQ.
package ahb_arbiter_pkg;

  localparam int AHB_MASTER_BITS = 2;
  localparam logic [AHB_MASTER_BITS-1:0] AHB_MASTER_0 = 2'd0;
  localparam logic [AHB_MASTER_BITS-1:0] AHB_MASTER_1 = 2'd1;
  localparam logic [AHB_MASTER_BITS-1:0] AHB_MASTER_2 = 2'd2;

  localparam int AHB_TRANS_BITS = 2;
  localparam logic [AHB_TRANS_BITS-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [AHB_TRANS_BITS-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [AHB_TRANS_BITS-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [AHB_TRANS_BITS-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam int BEAT_BITS = 4;

  function automatic logic [BEAT_BITS-1:0] burst_beats(input logic [2:0] hburst);
    logic [BEAT_BITS-1:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_burst_cnt.sv
// Remaining-beat counter for the current owner's burst; any non-OKAY response
// clears it so the arbiter can rearbitrate on the next ready cycle.
module ahb_burst_cnt
  import ahb_arbiter_pkg::*;
(
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      hready_i,
  input  logic [AHB_TRANS_BITS-1:0] htrans_i,
  input  logic [2:0]                hburst_i,
  input  logic [1:0]                hresp_i,
  output logic [BEAT_BITS-1:0]      cnt_o
);

  logic [BEAT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hresp_i != HRESP_OKAY) begin
      cnt_d = '0;
    end else if (hready_i) begin
      case (htrans_i)
        HTRANS_NONSEQ: cnt_d = burst_beats(hburst_i);
        HTRANS_SEQ:    cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        default:       cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter: round-robin grants at burst/lock boundaries,
// registered HMASTER/HMASTLOCK following the grant by one ready edge.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
(
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HREADY,
  input  logic [AHB_TRANS_BITS-1:0]  HTRANS,
  input  logic [2:0]                 HBURST,
  input  logic [1:0]                 HRESP,
  input  logic                       HBUSREQ_M1,
  input  logic                       HBUSREQ_M2,
  input  logic                       HLOCK_M1,
  input  logic                       HLOCK_M2,
  output logic                       HGRANT_M1,
  output logic                       HGRANT_M2,
  output logic [AHB_MASTER_BITS-1:0] HMASTER,
  output logic                       HMASTLOCK
);

  logic [BEAT_BITS-1:0]       beat_cnt;
  logic                       grant1_q, grant1_d, grant2_q, grant2_d;
  logic [AHB_MASTER_BITS-1:0] rr_last_q, rr_last_d;
  logic [AHB_MASTER_BITS-1:0] hmaster_q, hmaster_d;
  logic                       mastlock_q, mastlock_d;
  logic                       owner_lock, arb_point;

  ahb_burst_cnt u_burst_cnt (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .hready_i (HREADY),
    .htrans_i (HTRANS),
    .hburst_i (HBURST),
    .hresp_i  (HRESP),
    .cnt_o    (beat_cnt)
  );

  assign owner_lock = ((hmaster_q == AHB_MASTER_1) && HLOCK_M1) ||
                      ((hmaster_q == AHB_MASTER_2) && HLOCK_M2);
  // Arbitrate on the last beat (or idle), unless the owner holds a lock.
  assign arb_point  = HREADY && (beat_cnt <= 4'd1) && !(mastlock_q && owner_lock);

  always_comb begin
    grant1_d  = grant1_q;
    grant2_d  = grant2_q;
    rr_last_d = rr_last_q;
    if (arb_point) begin
      case ({HBUSREQ_M2, HBUSREQ_M1})
        2'b01:   begin grant1_d = 1'b1; grant2_d = 1'b0; end
        2'b10:   begin grant1_d = 1'b0; grant2_d = 1'b1; end
        2'b11:   begin
          grant1_d = (rr_last_q != AHB_MASTER_1);
          grant2_d = (rr_last_q == AHB_MASTER_1);
        end
        default: begin grant1_d = 1'b0; grant2_d = 1'b0; end
      endcase
      if (grant1_d)      rr_last_d = AHB_MASTER_1;
      else if (grant2_d) rr_last_d = AHB_MASTER_2;
    end
  end

  // Address-phase ownership follows the registered grant one ready edge later.
  always_comb begin
    hmaster_d  = hmaster_q;
    mastlock_d = mastlock_q;
    if (HREADY) begin
      hmaster_d  = grant1_q ? AHB_MASTER_1 : (grant2_q ? AHB_MASTER_2 : AHB_MASTER_0);
      mastlock_d = (grant1_q && HLOCK_M1) || (grant2_q && HLOCK_M2);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant1_q   <= 1'b0;
      grant2_q   <= 1'b0;
      rr_last_q  <= AHB_MASTER_2;
      hmaster_q  <= AHB_MASTER_0;
      mastlock_q <= 1'b0;
    end else begin
      grant1_q   <= grant1_d;
      grant2_q   <= grant2_d;
      rr_last_q  <= rr_last_d;
      hmaster_q  <= hmaster_d;
      mastlock_q <= mastlock_d;
    end
  end

  assign HGRANT_M1 = grant1_q;
  assign HGRANT_M2 = grant2_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = mastlock_q;

endmodule
